// File: rtl/dmux_stream.sv
// 1-to-N stream demultiplexer with a one-entry register per output channel.
// Unicast goes to in_sel; broadcast loads every channel in one all-or-nothing transfer.
module dmux_stream #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_bcast,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [(2**SEL_W)*WIDTH-1:0] out_data,
    output logic [2**SEL_W-1:0]         out_valid,
    input  logic [2**SEL_W-1:0]         out_ready,
    output logic                        busy
);
    localparam int N = 2**SEL_W;

    logic [N-1:0]            vld_q, vld_d;
    logic [N-1:0][WIDTH-1:0] dat_q, dat_d;
    logic [N-1:0]            can_acc;
    logic [N-1:0]            load;
    logic                    accept;

    // A channel can take a word if it is empty or is being drained this cycle.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        load     = '0;
        can_acc  = ~vld_q | out_ready;
        in_ready = !rst && (in_bcast ? &can_acc : can_acc[in_sel]);
        accept   = in_valid & in_ready;
        for (int i = 0; i < N; i++) begin
            load[i] = accept & (in_bcast | (in_sel == SEL_W'(i)));
            if (load[i]) begin
                vld_d[i] = 1'b1;
                dat_d[i] = in_data;
            end else if (out_ready[i]) begin
                vld_d[i] = 1'b0;
            end
        end
    end

    // NOTE: the data registers are reset too, because out_data must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = dat_q;
    assign busy      = |vld_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Self-checking bench for dmux_stream: directed vector table, scripted corner sequences,
// and randomized traffic scored against a per-channel queue model.
module tb_dmux_stream;
    localparam int WIDTH = 8;
    localparam int SEL_W = 3;
    localparam int N     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_bcast;
    logic             in_valid;
    logic             in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;
    logic             busy;

    int n_vec = 0;
    int n_bad = 0;

    dmux_stream #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, vld, bc;
        logic [2:0]  sel;
        logic [7:0]  dat, rdy;
        logic        exp_ir;
        logic [7:0]  exp_ov;
        int          ch;
        logic [7:0]  exp_slice;
        logic        full_en;
        logic [63:0] exp_full;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic v, input logic b, input logic [2:0] s,
                                input logic [7:0] d, input logic [7:0] rd, input logic ir,
                                input logic [7:0] ov, input int ch, input logic [7:0] sl,
                                input logic fe, input logic [63:0] fv);
        vec_t t;
        t.rst = r; t.vld = v; t.bc = b; t.sel = s; t.dat = d; t.rdy = rd;
        t.exp_ir = ir; t.exp_ov = ov; t.ch = ch; t.exp_slice = sl;
        t.full_en = fe; t.exp_full = fv;
        tbl.push_back(t);
    endfunction

    // Reference model: one queue per channel; the sink pops, the source pushes.
    logic [7:0] mq [N][$];

    task automatic mcycle(input logic v, input logic b, input logic [2:0] s,
                          input logic [7:0] d, input logic [7:0] rd, input string tag);
        logic ok;
        logic [7:0] ov;
        @(negedge clk);
        rst = 1'b0; in_valid = v; in_bcast = b; in_sel = s; in_data = d; out_ready = rd;
        #1;
        ok = 1'b1;
        for (int c = 0; c < N; c++)
            if ((b || s == 3'(c)) && mq[c].size() != 0 && !rd[c]) ok = 1'b0;
        check({tag, " in_ready"}, in_ready, ok);
        for (int c = 0; c < N; c++) begin
            if (rd[c] && mq[c].size() != 0) begin
                check($sformatf("%s taken ch%0d", tag, c), out_data[c*8 +: 8], mq[c][0]);
                void'(mq[c].pop_front());
            end
        end
        if (v && ok)
            for (int c = 0; c < N; c++)
                if (b || s == 3'(c)) mq[c].push_back(d);
        @(posedge clk);
        #1;
        ov = '0;
        for (int c = 0; c < N; c++) ov[c] = (mq[c].size() != 0);
        check({tag, " out_valid"}, out_valid, ov);
        check({tag, " busy"}, busy, |ov);
        for (int c = 0; c < N; c++)
            if (mq[c].size() != 0)
                check($sformatf("%s data ch%0d", tag, c), out_data[c*8 +: 8], mq[c][0]);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;

        // reset held two cycles with a word offered
        add(1,1,0,3'd0,8'h77,8'h00, 0,8'h00, 0,8'h00, 1,64'h0);
        add(1,1,0,3'd0,8'h77,8'h00, 0,8'h00, 0,8'h00, 1,64'h0);
        // unicast latency
        add(0,1,0,3'd5,8'hA5,8'hFF, 1,8'h20, 5,8'hA5, 0,64'h0);
        add(0,0,0,3'd5,8'h00,8'hFF, 1,8'h00, 5,8'hA5, 0,64'h0);
        // isolation: channel 2 stalled
        add(0,1,0,3'd2,8'h11,8'hFB, 1,8'h04, 2,8'h11, 0,64'h0);
        add(0,1,0,3'd2,8'h22,8'hFB, 0,8'h04, 2,8'h11, 0,64'h0);
        add(0,1,0,3'd6,8'h33,8'hFB, 1,8'h44, 6,8'h33, 0,64'h0);
        add(0,1,0,3'd2,8'h22,8'hFF, 1,8'h04, 2,8'h22, 0,64'h0);
        add(0,0,0,3'd2,8'h00,8'hFF, 1,8'h00, -1,8'h00, 0,64'h0);
        // drain and refill back to back on channel 3
        for (int k = 1; k <= 8; k++)
            add(0,1,0,3'd3,8'(k),8'h08, 1,8'h08, 3,8'(k), 0,64'h0);
        add(0,0,0,3'd3,8'h00,8'h08, 1,8'h00, -1,8'h00, 0,64'h0);
        // broadcast blocked by a stalled full channel 7, then released
        add(0,1,0,3'd7,8'h70,8'h00, 1,8'h80, 7,8'h70, 0,64'h0);
        add(0,1,1,3'd0,8'h5A,8'h7F, 0,8'h80, 7,8'h70, 0,64'h0);
        add(0,1,1,3'd0,8'h5A,8'h80, 1,8'hFF, 0,8'h5A, 1,{8{8'h5A}});
        add(0,0,0,3'd0,8'h00,8'hFF, 1,8'h00, -1,8'h00, 0,64'h0);
        // reset mid-operation discards buffered words
        add(0,1,0,3'd0,8'hC0,8'h00, 1,8'h01, 0,8'hC0, 0,64'h0);
        add(0,1,0,3'd1,8'hC1,8'h00, 1,8'h03, 1,8'hC1, 0,64'h0);
        add(0,1,0,3'd4,8'hC4,8'h00, 1,8'h13, 4,8'hC4, 0,64'h0);
        add(1,1,0,3'd2,8'h99,8'h00, 0,8'h00, -1,8'h00, 1,64'h0);
        add(0,0,0,3'd2,8'h00,8'h00, 1,8'h00, -1,8'h00, 1,64'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; in_valid = tbl[i].vld; in_bcast = tbl[i].bc;
            in_sel = tbl[i].sel; in_data = tbl[i].dat; out_ready = tbl[i].rdy;
            #1;
            check($sformatf("v%0d in_ready", i), in_ready, tbl[i].exp_ir);
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), out_valid, tbl[i].exp_ov);
            check($sformatf("v%0d busy", i), busy, |tbl[i].exp_ov);
            if (tbl[i].ch >= 0)
                check($sformatf("v%0d slice%0d", i, tbl[i].ch),
                      out_data[tbl[i].ch*8 +: 8], tbl[i].exp_slice);
            if (tbl[i].full_en)
                check($sformatf("v%0d out_data", i), out_data, tbl[i].exp_full);
        end

        // Scripted corners on the model: fill everything, blocked broadcast, replacing broadcast.
        for (int c = 0; c < N; c++) mq[c].delete();
        for (int c = 0; c < N; c++) mcycle(1, 0, 3'(c), 8'(8'hE0 + c), 8'h00, "fill");
        mcycle(1, 1, 3'd0, 8'hB7, 8'hFE, "bc_blocked");
        mcycle(1, 1, 3'd0, 8'hB8, 8'hFF, "bc_replace");
        mcycle(1, 0, 3'd3, 8'h3C, 8'hF7, "full_stall");
        mcycle(1, 0, 3'd3, 8'h3C, 8'hFF, "drain_load");
        mcycle(0, 0, 3'd0, 8'h00, 8'hFF, "empty");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic v, b;
            logic [7:0] rd;
            v  = ($urandom_range(0, 9) < 7);
            b  = ($urandom_range(0, 9) == 0);
            rd = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            mcycle(v, b, 3'($urandom_range(0, 7)), 8'($urandom), rd, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
